// File: rtl/fir_sat_pkg.sv
// Shared types and helpers for the time-multiplexed saturating FIR.
package fir_sat_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StMac,
      StOut
   } state_e;

   // Largest signed value representable in w bits, sign-extended to 64 bits.
   function automatic logic signed [63:0] sat_max(input int unsigned w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Most negative signed value representable in w bits, sign-extended to 64 bits.
   function automatic logic signed [63:0] sat_min(input int unsigned w);
      return -(64'sd1 <<< (w - 1));
   endfunction

   // Index width for a bank of taps entries; a single tap still needs one bit.
   function automatic int unsigned idx_w(input int unsigned taps);
      return (taps > 1) ? $clog2(taps) : 1;
   endfunction

endpackage

// File: rtl/fir_sat_add.sv
// Combinational signed adder with selectable saturate or two's-complement wrap.
module fir_sat_add
   import fir_sat_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic                sat_mode,
   output logic signed [W-1:0] y,
   output logic                ovf
);

   localparam logic signed [W-1:0] MaxV = W'(sat_max(W));
   localparam logic signed [W-1:0] MinV = W'(sat_min(W));

   logic [W:0] sum;

   // Widen by one bit to detect overflow, then clamp or wrap.
   always_comb begin
      sum = {a[W-1], a} + {b[W-1], b};
      ovf = sum[W] ^ sum[W-1];
      y   = sum[W-1:0];
      if (ovf && sat_mode) begin
         // Overflow with both operands negative can only go below min.
         y = (a[W-1] && b[W-1]) ? MinV : MaxV;
      end
   end

endmodule

// File: rtl/fir_sat_mac_seq.sv
// FIR filter evaluating one tap per cycle on a single saturating MAC datapath.
module fir_sat_mac_seq
   import fir_sat_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned COEF_W = 16,
   parameter int unsigned FRAC_W = 15,
   parameter int unsigned TAPS   = 4
) (
   input  logic                       system1000,
   input  logic                       system1000_rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [DATA_W-1:0]   in_data,
   input  logic                       coef_we,
   input  logic [idx_w(TAPS)-1:0]     coef_addr,
   input  logic signed [COEF_W-1:0]   coef_data,
   input  logic                       sat_mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [DATA_W-1:0]   out_data,
   output logic                       ovf,
   input  logic                       ovf_clr
);

   localparam int unsigned IDX_W  = idx_w(TAPS);
   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam logic signed [DATA_W-1:0] MaxV = DATA_W'(sat_max(DATA_W));
   localparam logic signed [DATA_W-1:0] MinV = DATA_W'(sat_min(DATA_W));

   state_e                    state_q, state_d;
   logic signed [DATA_W-1:0]  x_q [TAPS];
   logic signed [COEF_W-1:0]  c_q [TAPS];
   logic signed [DATA_W-1:0]  acc_q;
   logic [IDX_W-1:0]          idx_q;
   logic                      mode_q;
   logic                      ovf_q, ovf_d;

   logic                      accept;
   logic                      mac_step;
   logic                      last_tap;
   logic                      coef_wr;
   logic signed [PROD_W-1:0]  prod;
   logic signed [PROD_W-1:0]  shifted;
   logic [PROD_W-DATA_W:0]    prod_hi;
   logic                      scale_ovf;
   logic signed [DATA_W-1:0]  scaled;
   logic signed [DATA_W-1:0]  acc_sum;
   logic                      add_ovf;

   assign last_tap = (idx_q == IDX_W'(TAPS - 1));
   assign coef_wr  = coef_we && (state_q == StIdle) && (32'(coef_addr) < TAPS);
   assign out_data = acc_q;
   assign ovf      = ovf_q;

   // FSM next state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      mac_step  = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = StMac;
            end
         end
         StMac: begin
            mac_step = 1'b1;
            if (last_tap) state_d = StOut;
         end
         StOut: begin
            out_valid = 1'b1;
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Scale the full-precision product back to sample width; floor via arithmetic shift.
   always_comb begin
      prod      = x_q[idx_q] * c_q[idx_q];
      shifted   = prod >>> FRAC_W;
      // In range only when every bit above the sample sign bit matches it.
      prod_hi   = shifted[PROD_W-1:DATA_W-1];
      scale_ovf = ~((&prod_hi) | ~(|prod_hi));
      scaled    = shifted[DATA_W-1:0];
      if (scale_ovf && mode_q) begin
         scaled = shifted[PROD_W-1] ? MinV : MaxV;
      end
   end

   fir_sat_add #(
      .W (DATA_W)
   ) u_add (
      .a        (acc_q),
      .b        (scaled),
      .sat_mode (mode_q),
      .y        (acc_sum),
      .ovf      (add_ovf)
   );

   // Sticky overflow: a new event in the same cycle beats a clear.
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (mac_step && (scale_ovf || add_ovf)) ovf_d = 1'b1;
   end

   // State, overflow flag and latched mode.
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         state_q <= StIdle;
         ovf_q   <= 1'b0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
         if (accept) mode_q <= sat_mode;
      end
   end

   // Delay line shifts once per accepted sample.
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         for (int unsigned k = 0; k < TAPS; k++) x_q[k] <= '0;
      end else if (accept) begin
         x_q[0] <= in_data;
         for (int unsigned k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end
   end

   // Coefficient bank; writable only while idle.
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         for (int unsigned k = 0; k < TAPS; k++) c_q[k] <= '0;
      end else if (coef_wr) begin
         c_q[coef_addr] <= coef_data;
      end
   end

   // Tap index and accumulator for the in-flight sample.
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         idx_q <= '0;
         acc_q <= '0;
      end else if (accept) begin
         idx_q <= '0;
         acc_q <= '0;
      end else if (mac_step) begin
         acc_q <= acc_sum;
         if (!last_tap) idx_q <= idx_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_fir_sat_mac_seq.sv
// Self-checking bench for fir_sat_mac_seq with a plain-arithmetic reference model.
module tb_fir_sat_mac_seq;

   localparam int NT = 4;
   localparam int FW = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        coef_we = 1'b0;
   logic [1:0]  coef_addr = '0;
   logic [15:0] coef_data = '0;
   logic        sat_mode = 1'b1;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        ovf;
   logic        ovf_clr = 1'b0;

   int   n_vec = 0;
   int   n_err = 0;

   // Reference state: sample history, coefficients, sticky overflow.
   int   m_x [NT];
   int   m_c [NT];
   logic m_ovf;

   always #5 clk = ~clk;

   fir_sat_mac_seq #(
      .DATA_W (16),
      .COEF_W (16),
      .FRAC_W (15),
      .TAPS   (NT)
   ) dut (
      .system1000     (clk),
      .system1000_rst (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .coef_we        (coef_we),
      .coef_addr      (coef_addr),
      .coef_data      (coef_data),
      .sat_mode       (sat_mode),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .ovf            (ovf),
      .ovf_clr        (ovf_clr)
   );

   task automatic model_reset();
      for (int k = 0; k < NT; k++) begin
         m_x[k] = 0;
         m_c[k] = 0;
      end
      m_ovf = 1'b0;
   endtask

   // Bring a value into 16-bit signed range by clamping or wrapping.
   task automatic model_fit(inout longint v, input logic mode);
      logic signed [15:0] t;
      if (v > 32767 || v < -32768) begin
         m_ovf = 1'b1;
         if (mode) begin
            v = (v > 0) ? 64'sd32767 : -64'sd32768;
         end else begin
            t = v[15:0];
            v = t;
         end
      end
   endtask

   task automatic model_sample(input logic [15:0] d, input logic mode, output logic [15:0] y);
      longint acc;
      longint s;
      for (int k = NT - 1; k > 0; k--) m_x[k] = m_x[k-1];
      m_x[0] = int'($signed(d));
      acc = 0;
      for (int k = 0; k < NT; k++) begin
         s = (longint'(m_x[k]) * longint'(m_c[k])) >>> FW;
         model_fit(s, mode);
         acc = acc + s;
         model_fit(acc, mode);
      end
      y = acc[15:0];
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      ovf_clr  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (!in_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic write_coef(input int a, input logic [15:0] v);
      wait_idle();
      coef_we   = 1'b1;
      coef_addr = a[1:0];
      coef_data = v;
      @(negedge clk);
      coef_we = 1'b0;
      if (a < NT) m_c[a] = int'($signed(v));
   endtask

   task automatic write_all(input logic [15:0] v);
      for (int k = 0; k < NT; k++) write_coef(k, v);
   endtask

   // Send one sample and return at the negedge of the cycle out_valid is seen.
   // lat counts cycles from the accept cycle; -1 means the result never came.
   task automatic run_sample(input logic [15:0] d, input logic mode,
                             output logic [15:0] got, output int lat, output logic got_ovf);
      wait_idle();
      in_valid = 1'b1;
      in_data  = d;
      sat_mode = mode;
      @(negedge clk);
      in_valid = 1'b0;
      sat_mode = ~mode;  // flipping mode mid-flight must not affect this sample
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = -1;
      got     = out_data;
      got_ovf = ovf;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_vec++;
      if (ovf !== 1'b0) begin
         n_err++; $display("FAIL reset_ovf: got %b want 0", ovf);
      end
      n_vec++;
      if (out_data !== 16'h0000) begin
         n_err++; $display("FAIL reset_out_data: got %h want 0000", out_data);
      end
   endtask

   task automatic test_basic();
      logic [15:0] want [4];
      logic [15:0] got, exp;
      logic        g_ovf;
      int          lat;
      want = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
      do_reset();
      write_all(16'h4000);
      for (int i = 0; i < 4; i++) begin
         run_sample(16'h2000, 1'b1, got, lat, g_ovf);
         model_sample(16'h2000, 1'b1, exp);
         n_vec++;
         if (got !== want[i]) begin
            n_err++; $display("FAIL basic_data[%0d]: got %h want %h", i, got, want[i]);
         end
         n_vec++;
         if (lat != NT + 1) begin
            n_err++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, NT + 1);
         end
      end
      n_vec++;
      if (ovf !== 1'b0) begin
         n_err++; $display("FAIL basic_ovf: got %b want 0", ovf);
      end
   endtask

   task automatic test_pos_sat();
      logic [15:0] got, exp;
      logic        g_ovf;
      int          lat;
      for (int m = 1; m >= 0; m--) begin
         do_reset();
         write_all(16'h7FFF);
         for (int i = 0; i < 4; i++) begin
            run_sample(16'h7FFF, m[0], got, lat, g_ovf);
            model_sample(16'h7FFF, m[0], exp);
            n_vec++;
            if (got !== exp) begin
               n_err++; $display("FAIL pos_model[m%0d,%0d]: got %h want %h", m, i, got, exp);
            end
         end
         n_vec++;
         if (got !== (m[0] ? 16'h7FFF : 16'hFFF8)) begin
            n_err++; $display("FAIL pos_final[m%0d]: got %h want %h", m, got,
                              m[0] ? 16'h7FFF : 16'hFFF8);
         end
         n_vec++;
         if (g_ovf !== 1'b1) begin
            n_err++; $display("FAIL pos_ovf[m%0d]: got %b want 1", m, g_ovf);
         end
      end
   endtask

   task automatic test_neg_sat();
      logic [15:0] got, exp;
      logic        g_ovf;
      int          lat;
      do_reset();
      write_all(16'h7FFF);
      for (int i = 0; i < 4; i++) begin
         run_sample(16'h8000, 1'b1, got, lat, g_ovf);
         model_sample(16'h8000, 1'b1, exp);
      end
      n_vec++;
      if (got !== 16'h8000) begin
         n_err++; $display("FAIL neg_final: got %h want 8000", got);
      end
      n_vec++;
      if (g_ovf !== 1'b1) begin
         n_err++; $display("FAIL neg_ovf: got %b want 1", g_ovf);
      end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      m_ovf   = 1'b0;
      n_vec++;
      if (ovf !== 1'b0) begin
         n_err++; $display("FAIL ovf_clr: got %b want 0", ovf);
      end
      // Clear held through a sample that overflows: the set must win.
      ovf_clr = 1'b1;
      run_sample(16'h8000, 1'b1, got, lat, g_ovf);
      ovf_clr = 1'b0;
      model_sample(16'h8000, 1'b1, exp);
      n_vec++;
      if (g_ovf !== m_ovf) begin
         n_err++; $display("FAIL ovf_set_wins: got %b want %b", g_ovf, m_ovf);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] got, exp;
      logic        g_ovf;
      int          lat;
      logic [15:0] d;
      d = 16'($urandom);
      out_ready = 1'b0;
      run_sample(d, 1'b1, got, lat, g_ovf);
      model_sample(d, 1'b1, exp);
      n_vec++;
      if (got !== exp) begin
         n_err++; $display("FAIL bp_data: got %h want %h", got, exp);
      end
      for (int i = 0; i < 6; i++) begin
         in_valid = i[0];
         in_data  = 16'h7777;
         @(negedge clk);
         n_vec++;
         if (out_data !== exp || out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_hold[%0d]: got %h/%b want %h/1", i, out_data, out_valid, exp);
         end
         n_vec++;
         if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_release: got %b want 1", in_ready);
      end
      d = 16'($urandom);
      run_sample(d, 1'b1, got, lat, g_ovf);
      model_sample(d, 1'b1, exp);
      n_vec++;
      if (got !== exp) begin
         n_err++; $display("FAIL bp_after: got %h want %h", got, exp);
      end
   endtask

   task automatic test_coef_lock();
      logic [15:0] got, exp;
      logic        g_ovf;
      int          lat;
      do_reset();
      write_all(16'h4000);
      wait_idle();
      in_valid = 1'b1;
      in_data  = 16'h2000;
      sat_mode = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      coef_we   = 1'b1;  // MAC cycle 2: must be ignored
      coef_addr = 2'd0;
      coef_data = 16'h0000;
      @(negedge clk);
      coef_we = 1'b0;
      lat = 3;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      model_sample(16'h2000, 1'b1, exp);
      n_vec++;
      if (out_data !== 16'h1000 || out_valid !== 1'b1) begin
         n_err++; $display("FAIL lock_mac_write: got %h/%b want 1000/1", out_data, out_valid);
      end
      write_coef(0, 16'h0000);
      run_sample(16'h2000, 1'b1, got, lat, g_ovf);
      model_sample(16'h2000, 1'b1, exp);
      n_vec++;
      if (got !== 16'h1000) begin
         n_err++; $display("FAIL lock_idle_write: got %h want 1000", got);
      end
      // Write coincident with accept applies to that same sample.
      wait_idle();
      coef_we   = 1'b1;
      coef_addr = 2'd1;
      coef_data = 16'h0000;
      in_valid  = 1'b1;
      in_data   = 16'h2000;
      sat_mode  = 1'b1;
      @(negedge clk);
      coef_we  = 1'b0;
      in_valid = 1'b0;
      m_c[1]   = 0;
      model_sample(16'h2000, 1'b1, exp);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      n_vec++;
      if (out_data !== 16'h1000 || out_valid !== 1'b1) begin
         n_err++; $display("FAIL lock_same_cycle: got %h/%b want 1000/1", out_data, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] got, exp;
      logic        g_ovf;
      int          lat;
      logic        saw;
      do_reset();
      write_all(16'h4000);
      wait_idle();
      in_valid = 1'b1;
      in_data  = 16'h2000;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) saw = 1'b1;
         @(negedge clk);
      end
      n_vec++;
      if (saw !== 1'b0) begin
         n_err++; $display("FAIL midreset_out_valid: got %b want 0", saw);
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL midreset_in_ready: got %b want 1", in_ready);
      end
      write_all(16'h4000);
      run_sample(16'h2000, 1'b1, got, lat, g_ovf);
      model_sample(16'h2000, 1'b1, exp);
      n_vec++;
      if (got !== 16'h1000 || lat != NT + 1) begin
         n_err++; $display("FAIL midreset_next: got %h lat %0d want 1000 lat %0d", got, lat, NT + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_q [$];
      logic [15:0] e;
      logic [15:0] want;
      logic        was_ready;
      int          outs = 0;
      int          last = -1;
      int          cyc = 0;
      wait_idle();
      out_ready = 1'b1;
      sat_mode  = 1'b1;
      in_data   = 16'($urandom);
      in_valid  = 1'b1;
      was_ready = in_ready;
      while (outs < 5 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (was_ready) begin
            model_sample(in_data, 1'b1, e);
            exp_q.push_back(e);
            in_data = 16'($urandom);
         end
         was_ready = in_ready;
         if (out_valid) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data;
            n_vec++;
            if (out_data !== want) begin
               n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", outs, out_data, want);
            end
            if (last >= 0) begin
               n_vec++;
               if (cyc - last != NT + 2) begin
                  n_err++; $display("FAIL b2b_period[%0d]: got %0d want %0d", outs, cyc - last, NT + 2);
               end
            end
            last = cyc;
            outs++;
         end
      end
      in_valid = 1'b0;
      n_vec++;
      if (outs != 5) begin
         n_err++; $display("FAIL b2b_count: got %0d want 5", outs);
      end
      // Drain the sample still in flight so the model stays aligned.
      while (exp_q.size() > 0 && cyc < 260) begin
         @(negedge clk);
         cyc++;
         if (out_valid) e = exp_q.pop_front();
      end
   endtask

   task automatic test_random();
      logic [15:0] got, exp, d;
      logic        g_ovf, mode;
      int          lat;
      do_reset();
      for (int k = 0; k < NT; k++) write_coef(k, 16'($urandom));
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            write_coef(int'($urandom_range(0, NT - 1)),
                       ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h2000)));
         end
         d    = 16'($urandom);
         mode = 1'($urandom);
         run_sample(d, mode, got, lat, g_ovf);
         model_sample(d, mode, exp);
         n_vec++;
         if (got !== exp || lat != NT + 1) begin
            n_err++; $display("FAIL rand_data[%0d]: got %h lat %0d want %h lat %0d", i, got, lat, exp, NT + 1);
         end
         n_vec++;
         if (g_ovf !== m_ovf) begin
            n_err++; $display("FAIL rand_ovf[%0d]: got %b want %b", i, g_ovf, m_ovf);
         end
         if ($urandom_range(0, 3) == 0) begin
            ovf_clr = 1'b1;
            @(negedge clk);
            ovf_clr = 1'b0;
            m_ovf   = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pos_sat();
      test_neg_sat();
      test_backpressure();
      test_coef_lock();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
